// File: rtl/mse_pkg.sv
// Shared types and default widths for the MSE accumulator and its
// subtract/square pipeline.
package mse_pkg;

  localparam int DEFAULT_DATA_WL = 16;
  localparam int DEFAULT_ACC_WL  = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sq_err_pipe.sv
// Two-stage pipeline: registered difference of two signed samples, then its
// registered square, with a valid bit travelling alongside.
module sq_err_pipe
  import mse_pkg::*;
#(
  parameter int DATA_WL = DEFAULT_DATA_WL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WL-1:0]     data_in,
  input  logic [DATA_WL-1:0]     data_ref,
  output logic [2*DATA_WL+1:0]   sq,
  output logic                   sq_valid
);

  localparam int DIFF_W = DATA_WL + 1;
  localparam int SQ_W   = 2 * DATA_WL + 2;

  logic [DIFF_W-1:0] diff;
  logic              diff_valid;
  logic [SQ_W-1:0]   diff_ext;
  logic [SQ_W-1:0]   prod;

  // One extra bit holds any difference of two DATA_WL-bit values exactly.
  assign diff_ext = {{(SQ_W - DIFF_W){diff[DIFF_W-1]}}, diff};
  assign prod     = diff_ext * diff_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_valid <= 1'b0;
      sq_valid   <= 1'b0;
    end else begin
      diff_valid <= in_valid;
      sq_valid   <= diff_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      diff <= {data_in[DATA_WL-1], data_in} - {data_ref[DATA_WL-1], data_ref};
    end
    if (diff_valid) begin
      sq <= prod;
    end
  end

endmodule

// File: rtl/mse_accumulator.sv
// Measures the mean squared error between two FIR outputs over a window of
// 2^LOG2_SAMPLES valid samples, after a fixed settling interval.
module mse_accumulator
  import mse_pkg::*;
#(
  parameter int DATA_WL       = DEFAULT_DATA_WL,
  parameter int ACC_WL        = DEFAULT_ACC_WL,
  parameter int LOG2_SAMPLES  = 10,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_WL-1:0] data_in,
  input  logic [DATA_WL-1:0] data_ref,
  output logic [ACC_WL-1:0]  mse_data,
  output logic               mse_valid,
  output logic               busy
);

  localparam int SQ_W  = 2 * DATA_WL + 2;
  localparam int SUM_W = max_int(ACC_WL, SQ_W) + 1;

  localparam logic [7:0]              SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]              SETTLE_ONE  = 8'd1;
  localparam logic [LOG2_SAMPLES-1:0] SAMPLE_ONE  = LOG2_SAMPLES'(1);
  localparam logic [SUM_W-1:0]        ACC_MAX     = SUM_W'({ACC_WL{1'b1}});

  state_t                  state;
  logic [7:0]              settle_cnt;
  logic [LOG2_SAMPLES-1:0] sample_cnt;
  logic                    drain_cnt;
  logic [ACC_WL-1:0]       acc;
  logic [ACC_WL-1:0]       acc_next;
  logic [SUM_W-1:0]        sum_ext;
  logic [SQ_W-1:0]         sq;
  logic                    sq_valid;
  logic                    accept;

  // Only samples inside the accumulation window enter the pipeline.
  assign accept = (state == ACCUM) && in_valid;

  sq_err_pipe #(
    .DATA_WL (DATA_WL)
  ) u_sq_err_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .data_in  (data_in),
    .data_ref (data_ref),
    .sq       (sq),
    .sq_valid (sq_valid)
  );

  // The sum is formed one bit wider than either operand so saturation is exact.
  always_comb begin
    sum_ext = SUM_W'(acc) + SUM_W'(sq);
    if (sum_ext > ACC_MAX) begin
      acc_next = '1;
    end else begin
      acc_next = sum_ext[ACC_WL-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if ((state == IDLE) && start) begin
      acc <= '0;
    end else if (sq_valid) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mse_valid  <= 1'b0;
      mse_data   <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      mse_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            settle_cnt <= '0;
            sample_cnt <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sample_cnt <= sample_cnt + SAMPLE_ONE;
            if (&sample_cnt) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        // Two cycles let the final sample clear both pipeline stages into acc.
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          mse_data  <= acc >> LOG2_SAMPLES;
          mse_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mse_accumulator.sv
// Scoreboard bench: a 64-bit and a saturating 32-bit accumulator see the same
// stimulus; expected results and pulse cycles are queued when samples are driven.
module tb_mse_accumulator;

  localparam int LOG2_SAMPLES  = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam int N_SAMPLES     = 1 << LOG2_SAMPLES;

  typedef struct {
    longint unsigned data;
    int              cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] data_in;
  logic [15:0] data_ref;
  logic [63:0] mse_data64;
  logic        mse_valid64;
  logic        busy64;
  logic [31:0] mse_data32;
  logic        mse_valid32;
  logic        busy32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q64[$];
  exp_t q32[$];
  exp_t e64;
  exp_t e32;
  longint unsigned last64;
  longint unsigned last32;

  mse_accumulator #(
    .DATA_WL       (16),
    .ACC_WL        (64),
    .LOG2_SAMPLES  (LOG2_SAMPLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .data_ref  (data_ref),
    .mse_data  (mse_data64),
    .mse_valid (mse_valid64),
    .busy      (busy64)
  );

  mse_accumulator #(
    .DATA_WL       (16),
    .ACC_WL        (32),
    .LOG2_SAMPLES  (LOG2_SAMPLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .data_ref  (data_ref),
    .mse_data  (mse_data32),
    .mse_valid (mse_valid32),
    .busy      (busy32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Any pulse must match the oldest queued prediction in value and cycle.
  always @(negedge clk) begin
    if (mse_valid64) begin
      if (q64.size() == 0) begin
        checkOutput("spurious_pulse64", 64'd1, 64'd0);
      end else begin
        e64 = q64.pop_front();
        checkOutput("mse64", mse_data64, e64.data);
        checkOutput("latency64", 64'(cyc), 64'(e64.cycle));
      end
    end
    if (mse_valid32) begin
      if (q32.size() == 0) begin
        checkOutput("spurious_pulse32", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        checkOutput("mse32", 64'(mse_data32), e32.data);
        checkOutput("latency32", 64'(cyc), 64'(e32.cycle));
      end
    end
  end

  task automatic applyStimulus(input logic signed [15:0] din, input logic signed [15:0] dref,
                               input bit rnd, input bit toggle, input bit repulse);
    longint sum;
    longint d;
    longint unsigned sat;
    int accepted;
    int last;
    bit phase;
    logic signed [15:0] a;
    logic signed [15:0] b;
    sum = 0;
    accepted = 0;
    last = 0;
    phase = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    // Valid-looking junk during settling must never reach the accumulator.
    for (int i = 0; i < SETTLE_CYCLES; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      data_in = 16'($urandom);
      data_ref = 16'($urandom);
      if (i == 0) checkOutput("busy_settle", 64'(busy64), 64'd1);
    end
    while (accepted < N_SAMPLES) begin
      @(posedge clk); #1;
      start = repulse && (accepted == 5);
      if (toggle) phase = ~phase;
      else phase = 1'b1;
      in_valid = phase;
      if (phase) begin
        a = rnd ? 16'($urandom) : din;
        b = rnd ? 16'($urandom) : dref;
        data_in = a;
        data_ref = b;
        d = longint'(a) - longint'(b);
        sum += d * d;
        accepted++;
        last = cyc;
      end else begin
        data_in = 16'($urandom);
        data_ref = 16'($urandom);
      end
    end
    sat = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : longint'(sum);
    last64 = longint'(sum) >> LOG2_SAMPLES;
    last32 = sat >> LOG2_SAMPLES;
    q64.push_back('{data: last64, cycle: last + 4});
    q32.push_back('{data: last32, cycle: last + 4});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      data_in = 16'($urandom);
      data_ref = 16'($urandom);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (q64.size() != 0 || q32.size() != 0); i++) @(posedge clk);
    if (q64.size() != 0 || q32.size() != 0) begin
      checkOutput("result_timeout", 64'(q64.size() + q32.size()), 64'd0);
      q64.delete();
      q32.delete();
    end
    @(posedge clk); #1;
    checkOutput("busy_idle64", 64'(busy64), 64'd0);
    checkOutput("busy_idle32", 64'(busy32), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    data_ref = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy64", 64'(busy64), 64'd0);
    checkOutput("reset_valid64", 64'(mse_valid64), 64'd0);
    checkOutput("reset_data64", mse_data64, 64'd0);
    checkOutput("reset_busy32", 64'(busy32), 64'd0);
    checkOutput("reset_data32", 64'(mse_data32), 64'd0);

    applyStimulus(16'sd1234, 16'sd1234, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'sd1003, 16'sd1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(-16'sd32768, 16'sd32767, 1'b0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold64", mse_data64, 64'd4294836225);
    checkOutput("hold32", 64'(mse_data32), 64'h0FFF_FFFF);
    checkOutput("valid_low64", 64'(mse_valid64), 64'd0);

    applyStimulus(16'sd5, 16'sd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(-16'sd7, 16'sd10, 1'b0, 1'b0, 1'b1);

    // Abort mid-window with start asserted alongside reset.
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      data_in = 16'd100;
      data_ref = 16'd0;
    end
    checkOutput("busy_accum64", 64'(busy64), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    checkOutput("abort_busy64", 64'(busy64), 64'd0);
    checkOutput("abort_busy32", 64'(busy32), 64'd0);
    checkOutput("abort_data64", mse_data64, 64'd0);
    checkOutput("abort_data32", 64'(mse_data32), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("abort_idle64", 64'(busy64), 64'd0);

    applyStimulus(16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd0, 16'sd0, 1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mse_accumulator.md
MSE_ACCUMULATOR -- requirements
Module: mse_accumulator

Interface
REQ-001 SHALL have parameter DATA_WL, default 16: width of the signed sample inputs.
REQ-002 SHALL have parameter ACC_WL, default 64: width of the accumulator and of the result.
REQ-003 SHALL have parameter LOG2_SAMPLES, default 10: averaging window of 2^LOG2_SAMPLES samples; legal range 1..20.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 64: cycles discarded after start while the FIR pipelines flush; legal range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a measurement.
REQ-008 SHALL have port in_valid, input, 1 bit: data_in and data_ref are valid this cycle.
REQ-009 SHALL have port data_in, input, DATA_WL bits: two's-complement output of the DUT FIR.
REQ-010 SHALL have port data_ref, input, DATA_WL bits: two's-complement output of the reference FIR.
REQ-011 SHALL have port mse_data, output, ACC_WL bits: mean squared error of the last completed window.
REQ-012 SHALL have port mse_valid, output, 1 bit: one-cycle pulse marking mse_data as newly updated.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SETTLE, ACCUM, DRAIN and DONE.
REQ-015 SHALL move IDLE->SETTLE on start; start in any other state is ignored.
REQ-016 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, regardless of in_valid, then enter ACCUM; the accumulator and sample counter clear on entry to SETTLE.
REQ-017 SHALL accept one sample per ACCUM cycle with in_valid=1; cycles with in_valid=0 are skipped and not counted.
REQ-018 SHALL compute stage 1 as diff = sign-extended data_in minus data_ref, registered at DATA_WL+1 bits with no overflow.
REQ-019 SHALL compute stage 2 as sq = diff*diff, registered unsigned at 2*DATA_WL+2 bits.
REQ-020 SHALL compute stage 3 as acc += sq, saturating at all-ones of ACC_WL.
REQ-021 SHALL enter DRAIN after the 2^LOG2_SAMPLES-th accepted sample and stay there 2 cycles, until the last sq is accumulated, then enter DONE.
REQ-022 SHALL, in DONE (one cycle), load mse_data = acc >> LOG2_SAMPLES (truncating) and pulse mse_valid=1, then return to IDLE.
REQ-023 SHALL give latency from the cycle the last sample is accepted to mse_valid=1 of exactly 4 cycles.
REQ-024 SHALL hold mse_data between windows; mse_valid SHALL be 0 outside DONE.
REQ-025 SHALL register only in-window samples in stage 1; samples arriving in SETTLE, DRAIN or IDLE never reach acc.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=IDLE, mse_data=0, mse_valid=0, busy=0, acc=0, counters=0 and pipeline valids=0.
REQ-027 SHALL let rst mid-measurement abort the window with no mse_valid pulse; rst dominates a simultaneous start.

Structure
REQ-028 SHALL place the state enum and default widths (DATA_WL, ACC_WL) in shared package mse_pkg.
REQ-029 SHALL implement stages 1-2 (subtract and square with valid) as sub-module sq_err_pipe; the FSM, counters and accumulator stay in mse_accumulator.

Verification
REQ-030 SHALL cover: LOG2_SAMPLES=4, SETTLE_CYCLES=4, data_in=data_ref=1234, in_valid=1 -> one mse_valid pulse, mse_data=0, 4+16+4 cycles after start.
REQ-031 SHALL cover: data_in=data_ref+3 constant -> acc=144, mse_data=9.
REQ-032 SHALL cover: data_in=-32768, data_ref=32767 -> diff=-65535, mse_data=4294836225 (no wrap).
REQ-033 SHALL cover: in_valid toggling 1/0, diff=2 -> mse_data=4, pulse delayed by the 16 gap cycles, junk data on in_valid=0 ignored.
REQ-034 SHALL cover: start re-pulsed during ACCUM -> ignored, exactly one pulse; rst during ACCUM -> no pulse, busy=0 next cycle, a new start gives a correct result.
REQ-035 SHALL cover: ACC_WL=32 with max diff, 16 samples -> acc saturates, mse_data=0x0FFFFFFF.
